// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers and parameter-range checks for the synchronous FIFO.
package sync_fifo_pkg;

   function automatic int depth_f(input int adr_w);
      return 1 << adr_w;
   endfunction

   function automatic int cnt_w_f(input int adr_w);
      return adr_w + 1;
   endfunction

   // Thresholds must be reachable by the occupancy count to be meaningful.
   function automatic bit lvl_ok_f(input int adr_w, input int af_lvl, input int ae_lvl);
      return (af_lvl >= 1) && (af_lvl <= depth_f(adr_w)) &&
             (ae_lvl >= 0) && (ae_lvl <= depth_f(adr_w) - 1);
   endfunction

endpackage

// File: rtl/sync_fifo_sdp_ram.sv
// Simple dual-port RAM: synchronous write, registered read, unreset array.
module sdp_ram_1ck
   import sync_fifo_pkg::*;
#(
   parameter int DAT_W = 8,
   parameter int ADR_W = 2
) (
   input  logic             CK_i,
   input  logic             SRST_i,
   input  logic             WE_i,
   input  logic [ADR_W-1:0] WA_i,
   input  logic [DAT_W-1:0] WD_i,
   input  logic             RE_i,
   input  logic [ADR_W-1:0] RA_i,
   output logic [DAT_W-1:0] RD_o
);

   logic [DAT_W-1:0] mem_q [depth_f(ADR_W)];
   logic [DAT_W-1:0] rd_q;

   always_ff @(posedge CK_i) begin
      if (WE_i) begin
         mem_q[WA_i] <= WD_i;
      end
   end

   always_ff @(posedge CK_i) begin
      if (SRST_i) begin
         rd_q <= '0;
      end else if (RE_i) begin
         rd_q <= mem_q[RA_i];
      end
   end

   assign RD_o = rd_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy count, threshold flags and sticky errors
// around a registered-read dual-port RAM.
module sync_fifo
   import sync_fifo_pkg::*;
#(
   parameter int C_DAT_W  = 72,
   parameter int C_ADR_W  = 10,
   parameter int C_AF_LVL = 2**C_ADR_W - 4,
   parameter int C_AE_LVL = 4
) (
   input  logic               CK_i,
   input  logic               SRST_i,
   input  logic               CLR_i,
   input  logic               WE_i,
   input  logic [C_DAT_W-1:0] WD_i,
   input  logic               RE_i,
   output logic [C_DAT_W-1:0] RD_o,
   output logic               RD_VLD_o,
   output logic               FULL_o,
   output logic               EMPTY_o,
   output logic               AFULL_o,
   output logic               AEMPTY_o,
   output logic [C_ADR_W:0]   CNT_o,
   output logic               OVF_o,
   output logic               UDF_o
);

   localparam int CW = cnt_w_f(C_ADR_W);
   localparam logic [CW-1:0] DEPTH_C = CW'(depth_f(C_ADR_W));
   localparam logic [CW-1:0] AF_C    = CW'(C_AF_LVL);
   localparam logic [CW-1:0] AE_C    = CW'(C_AE_LVL);

   generate
      if (!lvl_ok_f(C_ADR_W, C_AF_LVL, C_AE_LVL)) begin : g_bad_lvl
         $error("sync_fifo: C_AF_LVL or C_AE_LVL out of range");
      end
   endgenerate

   logic [C_ADR_W-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               vld_q, vld_d, ovf_q, ovf_d, udf_q, udf_d;
   logic               wr_ok, rd_ok;

   // Acceptance looks only at registered flags, so a same-cycle read never
   // frees space for a write and a same-cycle write never feeds a read.
   assign wr_ok = WE_i & ~FULL_o  & ~CLR_i & ~SRST_i;
   assign rd_ok = RE_i & ~EMPTY_o & ~CLR_i & ~SRST_i;

   always_comb begin
      wp_d  = wp_q;
      rp_d  = rp_q;
      cnt_d = cnt_q;
      vld_d = rd_ok;
      ovf_d = ovf_q | (WE_i & FULL_o);
      udf_d = udf_q | (RE_i & EMPTY_o);
      if (wr_ok) begin
         wp_d = wp_q + C_ADR_W'(1);
      end
      if (rd_ok) begin
         rp_d = rp_q + C_ADR_W'(1);
      end
      case ({wr_ok, rd_ok})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
      if (CLR_i) begin
         wp_d  = '0;
         rp_d  = '0;
         cnt_d = '0;
         vld_d = 1'b0;
         ovf_d = 1'b0;
         udf_d = 1'b0;
      end
   end

   always_ff @(posedge CK_i) begin
      if (SRST_i) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
         vld_q <= 1'b0;
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
         vld_q <= vld_d;
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end

   sdp_ram_1ck #(
      .DAT_W(C_DAT_W),
      .ADR_W(C_ADR_W)
   ) u_ram (
      .CK_i  (CK_i),
      .SRST_i(SRST_i),
      .WE_i  (wr_ok),
      .WA_i  (wp_q),
      .WD_i  (WD_i),
      .RE_i  (rd_ok),
      .RA_i  (rp_q),
      .RD_o  (RD_o)
   );

   assign RD_VLD_o = vld_q;
   assign CNT_o    = cnt_q;
   assign FULL_o   = (cnt_q == DEPTH_C);
   assign EMPTY_o  = (cnt_q == '0);
   assign AFULL_o  = (cnt_q >= AF_C);
   assign AEMPTY_o = (cnt_q <= AE_C);
   assign OVF_o    = ovf_q;
   assign UDF_o    = udf_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo (D=4, AF=3, AE=1) with a read-data scoreboard.
module tb_sync_fifo;

   logic       clk = 1'b0;
   logic       srst, clr, we, re;
   logic [7:0] wd;
   logic [7:0] rd;
   logic       rd_vld, full, empty, afull, aempty, ovf, udf;
   logic [2:0] cnt;

   int checks = 0;
   int passes = 0;
   logic [7:0] exp_q [$];
   logic [7:0] exp_pop;

   logic [7:0] fill_t   [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
   logic       fill_ae  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
   logic       fill_af  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
   logic       fill_ful [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
   logic [7:0] pass_rd  [6] = '{8'h01, 8'h02, 8'hA0, 8'hA1, 8'hA2, 8'hA3};

   sync_fifo #(
      .C_DAT_W(8), .C_ADR_W(2), .C_AF_LVL(3), .C_AE_LVL(1)
   ) dut (
      .CK_i(clk), .SRST_i(srst), .CLR_i(clr), .WE_i(we), .WD_i(wd), .RE_i(re),
      .RD_o(rd), .RD_VLD_o(rd_vld), .FULL_o(full), .EMPTY_o(empty),
      .AFULL_o(afull), .AEMPTY_o(aempty), .CNT_o(cnt), .OVF_o(ovf), .UDF_o(udf)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         passes++;
         $display("ok   %s = %0h", name, act);
      end
   endtask

   // Drive one cycle; returns 1 time unit after the clock edge.
   task automatic op(input logic w, input logic [7:0] d, input logic r,
                     input logic c, input logic s);
      we = w; wd = d; re = r; clr = c; srst = s;
      @(posedge clk);
      #1;
   endtask

   // Monitor: every RD_VLD_o pulse must match the oldest expected word.
   always @(negedge clk) begin
      if (rd_vld === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL rd_spurious: got %0h expected no read", rd);
         end else begin
            exp_pop = exp_q.pop_front();
            chk("rd_data", {24'h0, rd}, {24'h0, exp_pop});
         end
      end
   end

   initial begin
      op(0, 8'h00, 0, 0, 1);
      op(0, 8'h00, 0, 0, 1);
      op(0, 8'h00, 0, 0, 0);
      chk("rst_empty", empty, 1);
      chk("rst_aempty", aempty, 1);
      chk("rst_full", full, 0);
      chk("rst_afull", afull, 0);
      chk("rst_cnt", cnt, 0);
      chk("rst_vld", rd_vld, 0);
      chk("rst_rd", rd, 8'h00);
      chk("rst_ovf_udf", {ovf, udf}, 2'b00);

      for (int i = 0; i < 4; i++) begin
         op(1, fill_t[i], 0, 0, 0);
         chk("fill_cnt", cnt, i + 1);
         chk("fill_aempty", aempty, fill_ae[i]);
         chk("fill_afull", afull, fill_af[i]);
         chk("fill_full", full, fill_ful[i]);
      end
      op(1, 8'h55, 0, 0, 0);
      chk("ovf_set", ovf, 1);
      chk("ovf_cnt", cnt, 4);

      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(fill_t[i]);
         op(0, 8'h00, 1, 0, 0);
         chk("drain_vld", rd_vld, 1);
         chk("drain_cnt", cnt, 3 - i);
      end
      chk("drain_empty", empty, 1);
      op(0, 8'h00, 1, 0, 0);
      chk("udf_set", udf, 1);
      chk("udf_no_vld", rd_vld, 0);

      op(1, 8'h01, 0, 0, 0);
      op(1, 8'h02, 0, 0, 0);
      for (int i = 0; i < 6; i++) begin
         exp_q.push_back(pass_rd[i]);
         op(1, 8'hA0 + 8'(i), 1, 0, 0);
         chk("pass_cnt", cnt, 2);
      end
      op(0, 8'h00, 0, 1, 0);
      chk("clr_cnt", cnt, 0);
      chk("clr_sticky", {ovf, udf}, 2'b00);

      // Full with simultaneous write and read: only the read is taken.
      op(1, 8'hC0, 0, 0, 0);
      op(1, 8'hC1, 0, 0, 0);
      op(1, 8'hC2, 0, 0, 0);
      op(1, 8'hC3, 0, 0, 0);
      exp_q.push_back(8'hC0);
      op(1, 8'hC4, 1, 0, 0);
      chk("full_rw_cnt", cnt, 3);
      chk("full_rw_ovf", ovf, 1);
      exp_q.push_back(8'hC1);
      op(0, 8'h00, 1, 0, 0);
      exp_q.push_back(8'hC2);
      op(0, 8'h00, 1, 0, 0);
      exp_q.push_back(8'hC3);
      op(0, 8'h00, 1, 0, 0);
      chk("full_rw_drained", cnt, 0);

      // Empty with simultaneous write and read: only the write is taken.
      op(0, 8'h00, 0, 1, 0);
      op(1, 8'hD0, 1, 0, 0);
      chk("empty_rw_cnt", cnt, 1);
      chk("empty_rw_udf", udf, 1);
      chk("empty_rw_vld", rd_vld, 0);
      exp_q.push_back(8'hD0);
      op(0, 8'h00, 1, 0, 0);

      op(1, 8'h5A, 0, 0, 0);
      exp_q.push_back(8'h5A);
      op(0, 8'h00, 1, 0, 0);
      chk("lat_rd", rd, 8'h5A);
      chk("lat_cnt", cnt, 0);

      op(1, 8'hE0, 0, 0, 0);
      op(1, 8'hE1, 0, 0, 0);
      op(1, 8'hE2, 0, 0, 0);
      op(1, 8'hE3, 0, 0, 0);
      op(1, 8'hE4, 0, 0, 0);
      exp_q.push_back(8'hE0);
      op(0, 8'h00, 1, 0, 0);
      chk("preclr_cnt", cnt, 3);
      chk("preclr_ovf", ovf, 1);
      op(1, 8'hE5, 1, 1, 0);
      chk("clr2_cnt", cnt, 0);
      chk("clr2_empty", empty, 1);
      chk("clr2_sticky", {ovf, udf}, 2'b00);
      chk("clr2_vld", rd_vld, 0);
      chk("clr2_rd_hold", rd, 8'hE0);

      op(1, 8'hF0, 0, 0, 0);
      op(1, 8'hF1, 0, 0, 0);
      exp_q.push_back(8'hF0);
      op(0, 8'h00, 1, 0, 0);
      op(1, 8'hF2, 1, 0, 1);
      chk("srst_rd", rd, 8'h00);
      chk("srst_vld", rd_vld, 0);
      chk("srst_cnt", cnt, 0);
      chk("srst_flags", {empty, aempty, full, afull}, 4'b1100);
      op(0, 8'h00, 0, 0, 0);
      op(0, 8'h00, 0, 0, 0);

      chk("sb_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
